// File: rtl/xbar_ch_ord_ctrl_pkg.sv
// Shared types and constants for the crossbar per-channel ordering controller.
package mpc_types;

  localparam int XBAR_ENTRY_NUM = 8;
  localparam int XBAR_BANK_NUM  = 4;
  localparam int XBAR_PTR_W     = 3;
  localparam int XBAR_DATA_W    = 32;

  typedef logic [XBAR_PTR_W-1:0] xbar_ptr_t;

  typedef struct packed {
    logic [XBAR_DATA_W-1:0] data;
  } xbar_rsp_t;

  // Window pointers wrap naturally at 8 because they are exactly 3 bits wide.
  function automatic xbar_ptr_t xbar_ptr_inc(input xbar_ptr_t p);
    return p + xbar_ptr_t'(1);
  endfunction

endpackage

// File: rtl/xbar_ch_ord_ctrl_rsp_buf.sv
// xbar_ch_rsp_buf: 8-entry response store with four write ports and one read
// port. Holds the per-entry done bits and response data. The caller guarantees
// that enabled write ports target distinct entries and never the entry being
// cleared in the same cycle.
module xbar_ch_rsp_buf
  import mpc_types::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [XBAR_BANK_NUM-1:0]          wr_en,
  input  logic [XBAR_BANK_NUM*3-1:0]        wr_entry,
  input  logic [XBAR_BANK_NUM*DATA_W-1:0]   wr_data,
  input  logic                              clr_en,
  input  logic [2:0]                        clr_entry,
  input  logic [2:0]                        rd_entry,
  output logic [XBAR_ENTRY_NUM-1:0]         done,
  output logic [DATA_W-1:0]                 rd_data
);

  logic [DATA_W-1:0] mem [XBAR_ENTRY_NUM];

  // Done bits and data: bank writes set done and capture data, a retire clears done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= '0;
      for (int i = 0; i < XBAR_ENTRY_NUM; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < XBAR_ENTRY_NUM; i++) begin
        for (int k = 0; k < XBAR_BANK_NUM; k++) begin
          if (wr_en[k] && (wr_entry[k*3 +: 3] == xbar_ptr_t'(i))) begin
            done[i] <= 1'b1;
            mem[i]  <= wr_data[k*DATA_W +: DATA_W];
          end
        end
        if (clr_en && (clr_entry == xbar_ptr_t'(i))) begin
          done[i] <= 1'b0;
        end
      end
    end
  end

  // Single read port follows the caller's read pointer.
  always_comb begin
    rd_data = mem[rd_entry];
  end

endmodule

// File: rtl/xbar_ch_ord_ctrl.sv
// xbar_ch_ord_ctrl: per-channel ordering controller. Allocates window entries
// on upstream request accept, collects out-of-order bank responses and returns
// them upstream strictly in allocation order.
// Optional feature: define XBAR_CH_ORD_BYPASS_EN to let a bank response that
// targets the oldest entry reach upstream combinationally in the same cycle.
module xbar_ch_ord_ctrl
  import mpc_types::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              u_req_valid,
  output logic                              u_req_ready,
  output logic [2:0]                        w_ptr,
  output logic [2:0]                        r_ptr,
  input  logic [XBAR_BANK_NUM-1:0]          b_rsp_valid,
  input  logic [XBAR_BANK_NUM*3-1:0]        b_rsp_entry,
  input  logic [XBAR_BANK_NUM*DATA_W-1:0]   b_rsp_data,
  output logic                              u_rsp_valid,
  input  logic                              u_rsp_ready,
  output logic [DATA_W-1:0]                 u_rsp_data,
  output logic [3:0]                        occupancy,
  output logic                              err_sticky
);

  logic [XBAR_ENTRY_NUM-1:0] alloc_q;
  logic [XBAR_ENTRY_NUM-1:0] alloc_nxt;
  logic [XBAR_ENTRY_NUM-1:0] done;
  logic [DATA_W-1:0]         buf_rd_data;
  logic [XBAR_BANK_NUM-1:0]  bank_dup;
  logic [XBAR_BANK_NUM-1:0]  bank_ok;
  logic [XBAR_BANK_NUM-1:0]  wr_en;
  logic                      bank_err;
  logic                      req_fire;
  logic                      rsp_fire;
  logic                      head_ready;
  logic [3:0]                occ_nxt;

  // Flag banks that name the same entry as another bank in this cycle.
  always_comb begin
    bank_dup = '0;
    for (int k = 0; k < XBAR_BANK_NUM; k++) begin
      for (int j = 0; j < XBAR_BANK_NUM; j++) begin
        if ((j != k) && b_rsp_valid[k] && b_rsp_valid[j] &&
            (b_rsp_entry[k*3 +: 3] == b_rsp_entry[j*3 +: 3])) begin
          bank_dup[k] = 1'b1;
        end
      end
    end
  end

  // A response is legal only for an allocated, not-yet-done entry named once.
  always_comb begin
    bank_ok = '0;
    for (int k = 0; k < XBAR_BANK_NUM; k++) begin
      bank_ok[k] = b_rsp_valid[k] & alloc_q[b_rsp_entry[k*3 +: 3]] &
                   ~done[b_rsp_entry[k*3 +: 3]] & ~bank_dup[k];
    end
    bank_err = |(b_rsp_valid & ~bank_ok);
  end

  assign head_ready = alloc_q[r_ptr] & done[r_ptr];

`ifdef XBAR_CH_ORD_BYPASS_EN
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  logic              byp_retire;

  // A legal response to the still-pending oldest entry can be forwarded directly.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int k = 0; k < XBAR_BANK_NUM; k++) begin
      if (bank_ok[k] && (b_rsp_entry[k*3 +: 3] == r_ptr)) begin
        byp_hit  = 1'b1;
        byp_data = b_rsp_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Upstream sees the stored head first; the bypass only applies while it is pending.
  always_comb begin
    u_rsp_valid = head_ready | byp_hit;
    u_rsp_data  = head_ready ? buf_rd_data : (byp_hit ? byp_data : buf_rd_data);
    byp_retire  = byp_hit & ~head_ready & u_rsp_ready;
    wr_en       = bank_ok;
    for (int k = 0; k < XBAR_BANK_NUM; k++) begin
      if (byp_retire && (b_rsp_entry[k*3 +: 3] == r_ptr)) begin
        wr_en[k] = 1'b0;
      end
    end
  end
`else
  // Upstream only ever sees stored data, giving at least one cycle of latency.
  always_comb begin
    u_rsp_valid = head_ready;
    u_rsp_data  = buf_rd_data;
    wr_en       = bank_ok;
  end
`endif

  assign req_fire = u_req_valid & u_req_ready;
  assign rsp_fire = u_rsp_valid & u_rsp_ready;
  assign occ_nxt  = occupancy + {3'b000, req_fire} - {3'b000, rsp_fire};

  // Next alloc vector: retire clears the head, accept sets the tail.
  always_comb begin
    alloc_nxt = alloc_q;
    if (rsp_fire) begin
      alloc_nxt[r_ptr] = 1'b0;
    end
    if (req_fire) begin
      alloc_nxt[w_ptr] = 1'b1;
    end
  end

  // Allocation bits per entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q <= '0;
    end else begin
      alloc_q <= alloc_nxt;
    end
  end

  // Pointers, occupancy, registered ready (from next occupancy) and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      occupancy   <= '0;
      u_req_ready <= 1'b1;
      err_sticky  <= 1'b0;
    end else begin
      if (req_fire) begin
        w_ptr <= xbar_ptr_inc(w_ptr);
      end
      if (rsp_fire) begin
        r_ptr <= xbar_ptr_inc(r_ptr);
      end
      occupancy   <= occ_nxt;
      u_req_ready <= (occ_nxt < 4'(DEPTH));
      if (bank_err) begin
        err_sticky <= 1'b1;
      end
    end
  end

  xbar_ch_rsp_buf #(
    .DATA_W (DATA_W)
  ) u_rsp_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_entry  (b_rsp_entry),
    .wr_data   (b_rsp_data),
    .clr_en    (rsp_fire),
    .clr_entry (r_ptr),
    .rd_entry  (r_ptr),
    .done      (done),
    .rd_data   (buf_rd_data)
  );

endmodule

// File: tb/tb_xbar_ch_ord_ctrl.sv
// Bench for xbar_ch_ord_ctrl: directed scenarios followed by random traffic,
// checked every cycle against an in-order queue model of the request window.
module tb_xbar_ch_ord_ctrl;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            u_req_valid;
  logic            u_req_ready;
  logic [2:0]      w_ptr;
  logic [2:0]      r_ptr;
  logic [3:0]      b_rsp_valid;
  logic [11:0]     b_rsp_entry;
  logic [4*DW-1:0] b_rsp_data;
  logic            u_rsp_valid;
  logic            u_rsp_ready;
  logic [DW-1:0]   u_rsp_data;
  logic [3:0]      occupancy;
  logic            err_sticky;

  xbar_ch_ord_ctrl #(.DATA_W(DW), .DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .u_req_valid (u_req_valid),
    .u_req_ready (u_req_ready),
    .w_ptr       (w_ptr),
    .r_ptr       (r_ptr),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_entry (b_rsp_entry),
    .b_rsp_data  (b_rsp_data),
    .u_rsp_valid (u_rsp_valid),
    .u_rsp_ready (u_rsp_ready),
    .u_rsp_data  (u_rsp_data),
    .occupancy   (occupancy),
    .err_sticky  (err_sticky)
  );

  always #5 clk = ~clk;

  // Reference model: queue of outstanding entry ids, oldest first.
  int          q[$];
  bit          m_done[8];
  logic [31:0] m_data[8];
  bit          m_err;
  int          alloc_cnt;
  int          ret_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int e);
    foreach (q[i]) if (q[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 8; i++) begin
      m_done[i] = 1'b0;
      m_data[i] = '0;
    end
    m_err     = 1'b0;
    alloc_cnt = 0;
    ret_cnt   = 0;
  endtask

  task automatic banks_idle();
    b_rsp_valid = '0;
    b_rsp_entry = '0;
    b_rsp_data  = '0;
  endtask

  task automatic bank(input int k, input int e, input logic [31:0] d);
    b_rsp_valid[k]          = 1'b1;
    b_rsp_entry[k*3 +: 3]   = 3'(e);
    b_rsp_data[k*DW +: DW]  = d;
  endtask

  // Check one cycle's outputs against the model, then advance model across the edge.
  task automatic step();
    int          head;
    int          e;
    bit          good[4];
    bit          dup;
    bit          err_now;
    bit          exp_valid;
    logic [31:0] exp_data;
    bit          rsp_fire;
    bit          req_fire;
    bit          byp_retire;
    #1;
    head    = (q.size() > 0) ? q[0] : 0;
    err_now = 1'b0;
    for (int k = 0; k < 4; k++) begin
      good[k] = 1'b0;
      if (b_rsp_valid[k]) begin
        e   = int'(b_rsp_entry[k*3 +: 3]);
        dup = 1'b0;
        for (int j = 0; j < 4; j++)
          if (j != k && b_rsp_valid[j] && int'(b_rsp_entry[j*3 +: 3]) == e) dup = 1'b1;
        good[k] = in_q(e) && !m_done[e] && !dup;
        if (!good[k]) err_now = 1'b1;
      end
    end
    exp_valid = (q.size() > 0) && m_done[head];
    exp_data  = m_data[head];
`ifdef XBAR_CH_ORD_BYPASS_EN
    if (!exp_valid && q.size() > 0)
      for (int k = 0; k < 4; k++)
        if (good[k] && int'(b_rsp_entry[k*3 +: 3]) == head) begin
          exp_valid = 1'b1;
          exp_data  = b_rsp_data[k*DW +: DW];
        end
`endif
    chk("w_ptr", 32'(w_ptr), 32'(alloc_cnt % 8));
    chk("r_ptr", 32'(r_ptr), 32'(ret_cnt % 8));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("u_req_ready", 32'(u_req_ready), (q.size() < 8) ? 32'd1 : 32'd0);
    chk("u_rsp_valid", 32'(u_rsp_valid), exp_valid ? 32'd1 : 32'd0);
    if (exp_valid) chk("u_rsp_data", u_rsp_data, exp_data);
    chk("err_sticky", 32'(err_sticky), m_err ? 32'd1 : 32'd0);
    rsp_fire   = exp_valid && u_rsp_ready;
    req_fire   = u_req_valid && (q.size() < 8);
    byp_retire = rsp_fire && !m_done[head];
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (good[k]) begin
        e = int'(b_rsp_entry[k*3 +: 3]);
        if (!(byp_retire && e == head)) begin
          m_done[e] = 1'b1;
          m_data[e] = b_rsp_data[k*DW +: DW];
        end
      end
    if (err_now) m_err = 1'b1;
    if (rsp_fire) begin
      m_done[head] = 1'b0;
      void'(q.pop_front());
      ret_cnt++;
    end
    if (req_fire) begin
      q.push_back(alloc_cnt % 8);
      alloc_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    u_req_valid = 1'b0;
    u_rsp_ready = 1'b0;
    banks_idle();
    #1;
    chk("rst_w_ptr", 32'(w_ptr), 32'd0);
    chk("rst_r_ptr", 32'(r_ptr), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_u_req_ready", 32'(u_req_ready), 32'd1);
    chk("rst_u_rsp_valid", 32'(u_rsp_valid), 32'd0);
    chk("rst_u_rsp_data", u_rsp_data, 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic alloc_n(input int n);
    u_req_valid = 1'b1;
    repeat (n) step();
    u_req_valid = 1'b0;
  endtask

  // Respond to all outstanding entries (up to four per cycle) until the window empties.
  task automatic drain();
    int nb;
    u_req_valid = 1'b0;
    u_rsp_ready = 1'b1;
    for (int g = 0; g < 40 && q.size() > 0; g++) begin
      banks_idle();
      nb = 0;
      foreach (q[i])
        if (!m_done[q[i]] && nb < 4) begin
          bank(nb, q[i], $urandom);
          nb++;
        end
      step();
    end
    banks_idle();
    step();
    chk("drain_empty", 32'(occupancy), 32'd0);
  endtask

  task automatic random_phase(input int cycles, input bit with_errors);
    int cand[$];
    int idx;
    int e;
    for (int c = 0; c < cycles; c++) begin
      u_req_valid = ($urandom_range(0, 3) != 0);
      u_rsp_ready = ($urandom_range(0, 2) != 0);
      banks_idle();
      cand.delete();
      foreach (q[i]) if (!m_done[q[i]]) cand.push_back(q[i]);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 0) continue;
        if (with_errors && $urandom_range(0, 29) == 0) begin
          bank(k, $urandom_range(0, 7), $urandom);
        end else if (cand.size() > 0) begin
          idx = $urandom_range(0, cand.size() - 1);
          e   = cand[idx];
          cand.delete(idx);
          bank(k, e, $urandom);
        end
      end
      step();
    end
    banks_idle();
  endtask

  initial begin
    int base;
    model_clear();
    rst_n       = 1'b0;
    u_req_valid = 1'b0;
    u_rsp_ready = 1'b0;
    banks_idle();
    repeat (2) @(negedge clk);
    do_reset();

    // Fill and drain in order
    alloc_n(8);
    step();
    chk("full_occ", 32'(occupancy), 32'd8);
    chk("full_ready", 32'(u_req_ready), 32'd0);
    u_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      banks_idle();
      bank(i % 4, i, 32'h10 + 32'(i));
      step();
    end
    banks_idle();
    repeat (3) step();

    // Reverse return
    base = alloc_cnt % 8;
    alloc_n(4);
    for (int i = 3; i >= 0; i--) begin
      banks_idle();
      bank(i, (base + i) % 8, 32'h20 + 32'(i));
      step();
    end
    banks_idle();
    repeat (5) step();

    // Four banks in one cycle
    base = alloc_cnt % 8;
    alloc_n(4);
    for (int k = 0; k < 4; k++) bank(k, (base + k) % 8, 32'h30 + 32'(k));
    step();
    banks_idle();
    repeat (5) step();

    // Backpressure at full
    u_rsp_ready = 1'b0;
    base = alloc_cnt % 8;
    alloc_n(8);
    for (int k = 0; k < 4; k++) bank(k, (base + k) % 8, 32'h40 + 32'(k));
    step();
    banks_idle();
    for (int k = 0; k < 4; k++) bank(k, (base + 4 + k) % 8, 32'h44 + 32'(k));
    step();
    banks_idle();
    repeat (3) step();
    u_req_valid = 1'b1;
    u_rsp_ready = 1'b1;
    repeat (10) step();
    drain();

    // Errors: unallocated entry, then duplicate response
    base = alloc_cnt % 8;
    alloc_n(1);
    bank(0, (base + 5) % 8, 32'hDEAD);
    step();
    banks_idle();
    u_rsp_ready = 1'b0;
    bank(0, base, 32'hAA);
    step();
    banks_idle();
    bank(1, base, 32'hBB);
    step();
    banks_idle();
    step();
    u_rsp_ready = 1'b1;
    step();
    step();

    // Reset mid-stream, then a late response from before reset
    alloc_n(3);
    bank(2, (alloc_cnt - 2) % 8, 32'h55);
    step();
    banks_idle();
    do_reset();
    bank(0, 1, 32'h66);
    step();
    banks_idle();
    step();

    // Two banks on the same entry in one cycle
    do_reset();
    alloc_n(1);
    bank(0, 0, 32'h77);
    bank(1, 0, 32'h78);
    step();
    banks_idle();
    repeat (2) step();
    drain();

    // Single outstanding entry responded to with ready high
    do_reset();
    alloc_n(1);
    u_rsp_ready = 1'b1;
    bank(1, 0, 32'h99);
    step();
    banks_idle();
    repeat (2) step();

    // Random traffic without, then with, protocol errors
    do_reset();
    random_phase(400, 1'b0);
    drain();
    do_reset();
    random_phase(400, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
